// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch FSM with one outstanding request and redirect.
//            Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic [31:0] PC,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        wr_pc_valid,
    input  logic [31:0] wr_pc,
    output logic        fetch_misaligned
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_REQ   = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_HALT  = 3'd5;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic c_TRAP_EN = 1'b1;
`else
    localparam logic c_TRAP_EN = 1'b0;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] w_target;
    logic        w_bad_target;

    // Without the trap the low bits are simply dropped, so HALT is never entered.
    assign w_bad_target = c_TRAP_EN && (wr_pc[1:0] != 2'b00);
    assign w_target     = c_TRAP_EN ? wr_pc : {wr_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= c_IDLE;
            fetch_pc_q   <= RESET_VECTOR;
            inst_q       <= 32'd0;
            pc_q         <= 32'd0;
            inst_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        misaligned_d = misaligned_q;
        if (wr_pc_valid) begin
            fetch_pc_d   = w_target;
            inst_valid_d = 1'b0;
            if (w_bad_target) begin
                state_d      = c_HALT;
                misaligned_d = 1'b1;
            end else begin
                // A request already accepted must have its response drained.
                case (state_q)
                    c_REQ:           state_d = imem_req_ready ? c_DRAIN : c_REQ;
                    c_WAIT, c_DRAIN: state_d = imem_rsp_valid ? c_REQ : c_DRAIN;
                    default:         state_d = c_REQ;
                endcase
            end
        end else begin
            case (state_q)
                c_IDLE: state_d = c_REQ;
                c_REQ: begin
                    if (imem_req_ready) state_d = c_WAIT;
                end
                c_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_d       = imem_rsp_data;
                        pc_d         = fetch_pc_q;
                        fetch_pc_d   = fetch_pc_q + 32'd4;
                        inst_valid_d = 1'b1;
                        state_d      = c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (inst_ready) begin
                        inst_valid_d = 1'b0;
                        state_d      = c_REQ;
                    end
                end
                c_DRAIN: begin
                    if (imem_rsp_valid) state_d = c_REQ;
                end
                c_HALT:  state_d = c_HALT;
                default: state_d = c_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_valid   = rst && (state_q == c_REQ);
        imem_addr        = fetch_pc_q;
        inst             = inst_q;
        PC               = pc_q;
        inst_valid       = inst_valid_q;
        fetch_misaligned = misaligned_q;
    end

endmodule
`default_nettype wire
